// File: rtl/aq_cjpeg_bitpack.sv
// aq_cjpeg_bitpack: packs Huffman code fields MSB-first into byte-stuffed 32-bit words, with marker insertion and flush padding.
module aq_cjpeg_bitpack #(
  parameter int   CODE_WIDTH = 27,
  parameter logic PAD_BIT    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CodeValid,
  output logic                  CodeReady,
  input  logic [CODE_WIDTH-1:0] CodeData,
  input  logic [4:0]            CodeWidth,
  input  logic                  FlushValid,
  input  logic                  FlushEnd,
  output logic                  FlushReady,
  input  logic                  MarkerValid,
  input  logic [7:0]            MarkerData,
  output logic                  MarkerReady,
  output logic [31:0]           DataOut,
  output logic                  DataOutEnable,
  output logic                  DataOutLast,
  output logic [2:0]            DataOutBytes,
  input  logic                  DataOutFull,
  output logic                  EncodeIdle
);
  typedef enum logic [2:0] {RUN, PAD, DRAIN, TAIL, MARK_FF, MARK_CODE} state_t;
  state_t state, stateNext;
  logic [63:0] acc, accNext, accShift, field;
  logic [6:0] bitCount, cntShift, cntNext;
  logic [31:0] pkWord, pkWordNext;
  logic [2:0] pkCnt, pkCntNext, base, padW;
  logic [4:0] cw, appW;
  logic [CODE_WIDTH-1:0] appD;
  logic [7:0] markReg, pushByte;
  logic stuff, stuffNext, endReg;
  logic codeFire, flushFire, markFire, wordEmit, tailEmit, stall, extract, push, markAdv;
  always_comb begin
    CodeReady   = state == RUN && bitCount <= 7'd37;
    FlushReady  = state == RUN;
    MarkerReady = state == RUN && bitCount == 7'd0 && !CodeValid && !FlushValid;
    EncodeIdle  = state == RUN && bitCount == 7'd0 && pkCnt == 3'd0 && !stuff;
    codeFire  = CodeValid && CodeReady;
    flushFire = FlushValid && FlushReady;
    markFire  = MarkerValid && MarkerReady;
    // TAIL owns the emit path so a held full word still leaves flagged as last
    wordEmit = pkCnt == 3'd4 && !DataOutFull && state != TAIL;
    tailEmit = state == TAIL && !DataOutFull && pkCnt != 3'd0;
    stall    = pkCnt == 3'd4 && !wordEmit;
    extract  = !stall && !stuff && bitCount >= 7'd8;
    push     = !stall && (stuff || extract || state == MARK_FF || state == MARK_CODE);
    markAdv  = !stall && !stuff;
    pushByte = stuff ? 8'h00 : state == MARK_FF ? 8'hFF : state == MARK_CODE ? markReg : acc[63:56];
    stuffNext = stuff ? stall : extract && &acc[63:56];
    cntShift = extract ? bitCount - 7'd8 : bitCount;
    accShift = extract ? acc << 8 : acc;
    cw   = CodeWidth > 5'(CODE_WIDTH) ? 5'(CODE_WIDTH) : CodeWidth;
    padW = 3'd0 - cntShift[2:0];
    appW = codeFire ? cw : state == PAD ? {2'b00, padW} : 5'd0;
    appD = codeFire ? CodeData : {CODE_WIDTH{PAD_BIT}};
    field = 64'(appD & ~({CODE_WIDTH{1'b1}} << appW));
    accNext = accShift | (field << (7'd64 - cntShift - {2'b00, appW}));
    cntNext = cntShift + {2'b00, appW};
    base = (wordEmit || tailEmit) ? 3'd0 : pkCnt;
    pkCntNext = base + {2'b00, push};
    pkWordNext = ((wordEmit || tailEmit) ? 32'd0 : pkWord) |
                 (push ? 32'(pushByte) << {~base[1:0], 3'b000} : 32'd0);
    DataOutEnable = wordEmit || tailEmit;
    DataOutLast   = tailEmit;
    DataOutBytes  = DataOutEnable ? pkCnt : 3'd0;
    DataOut       = DataOutEnable ? pkWord : 32'd0;
    stateNext = state;
    case (state)
      RUN:       stateNext = flushFire ? PAD : markFire ? MARK_FF : RUN;
      PAD:       stateNext = (bitCount == 7'd0 && !stuff) ? DRAIN : PAD;
      DRAIN:     stateNext = endReg ? TAIL : RUN;
      TAIL:      stateNext = (pkCnt == 3'd0 || !DataOutFull) ? RUN : TAIL;
      MARK_FF:   stateNext = markAdv ? MARK_CODE : MARK_FF;
      MARK_CODE: stateNext = markAdv ? RUN : MARK_CODE;
      default:   stateNext = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      acc      <= '0;
      bitCount <= '0;
      stuff    <= 1'b0;
      pkWord   <= '0;
      pkCnt    <= '0;
      markReg  <= '0;
      endReg   <= 1'b0;
    end else begin
      state    <= stateNext;
      acc      <= accNext;
      bitCount <= cntNext;
      stuff    <= stuffNext;
      pkWord   <= pkWordNext;
      pkCnt    <= pkCntNext;
      markReg  <= markFire ? MarkerData : markReg;
      endReg   <= flushFire ? FlushEnd : endReg;
    end
  end
endmodule

// File: tb/tb_aq_cjpeg_bitpack.sv
// tb_aq_cjpeg_bitpack: directed scenarios for the scan bitstream packer with hand-computed words.
module tb_aq_cjpeg_bitpack;
  logic clk = 1'b0;
  logic rst, CodeValid, CodeReady, FlushValid, FlushEnd, FlushReady;
  logic MarkerValid, MarkerReady, DataOutEnable, DataOutLast, DataOutFull, EncodeIdle;
  logic [26:0] CodeData;
  logic [4:0] CodeWidth;
  logic [7:0] MarkerData;
  logic [31:0] DataOut;
  logic [2:0] DataOutBytes;
  int errors = 0, checks = 0, cyc = 0, fullViol = 0;
  logic [31:0] outW[$];
  int outB[$], outC[$];
  logic outL[$];
  bit bq[$];

  aq_cjpeg_bitpack dut (
    .clk(clk), .rst(rst), .CodeValid(CodeValid), .CodeReady(CodeReady), .CodeData(CodeData),
    .CodeWidth(CodeWidth), .FlushValid(FlushValid), .FlushEnd(FlushEnd), .FlushReady(FlushReady),
    .MarkerValid(MarkerValid), .MarkerData(MarkerData), .MarkerReady(MarkerReady), .DataOut(DataOut),
    .DataOutEnable(DataOutEnable), .DataOutLast(DataOutLast), .DataOutBytes(DataOutBytes),
    .DataOutFull(DataOutFull), .EncodeIdle(EncodeIdle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (DataOutEnable) begin
    outW.push_back(DataOut);
    outB.push_back(int'(DataOutBytes));
    outL.push_back(DataOutLast);
    outC.push_back(cyc);
    if (DataOutFull) fullViol++;
  end

  task automatic clearOut();
    outW.delete(); outB.delete(); outL.delete(); outC.delete();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendCode(input logic [26:0] d, input logic [4:0] w, output int accCyc);
    bit ok = 0;
    accCyc = -1;
    CodeData = d; CodeWidth = w; CodeValid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (CodeReady) begin ok = 1; accCyc = cyc; end
    end
    @(posedge clk); #1 CodeValid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL code_accept: CodeReady never seen, required 1"); end
  endtask

  task automatic sendFlush(input logic e);
    bit ok = 0;
    FlushValid = 1'b1; FlushEnd = e;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (FlushReady) ok = 1;
    end
    @(posedge clk); #1 FlushValid = 1'b0; FlushEnd = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL flush_accept: FlushReady never seen, required 1"); end
  endtask

  task automatic sendMarker(input logic [7:0] m);
    bit ok = 0;
    MarkerValid = 1'b1; MarkerData = m;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (MarkerReady) ok = 1;
    end
    @(posedge clk); #1 MarkerValid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL marker_accept: MarkerReady never seen, required 1"); end
  endtask

  task automatic checkWord(input string nm, input int k, input logic [31:0] w, input int b, input logic l);
    checks++;
    if (outW.size() <= k) begin
      errors++; $display("FAIL %s: only %0d words, required word %0d", nm, outW.size(), k);
    end else if (outW[k] !== w || outB[k] !== b || outL[k] !== l) begin
      errors++;
      $display("FAIL %s: got %h bytes=%0d last=%0d, required %h bytes=%0d last=%0d", nm, outW[k], outB[k], outL[k], w, b, l);
    end
  endtask

  task automatic checkCount(input string nm, input int n);
    checks++;
    if (outW.size() !== n) begin errors++; $display("FAIL %s: got %0d words, required %0d", nm, outW.size(), n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; CodeValid = 0; FlushValid = 0; FlushEnd = 0; MarkerValid = 0; DataOutFull = 0;
    CodeData = '0; CodeWidth = '0; MarkerData = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (EncodeIdle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b, required 1", EncodeIdle); end
    checks++; if (DataOutEnable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b, required 0", DataOutEnable); end
    checks++; if (DataOutLast !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, required 0", DataOutLast); end
    checks++; if (DataOutBytes !== 3'd0) begin errors++; $display("FAIL reset_bytes: got %0d, required 0", DataOutBytes); end
    checks++; if (DataOut !== 32'd0) begin errors++; $display("FAIL reset_data: got %h, required 0", DataOut); end
    checks++; if (CodeReady !== 1'b1 || FlushReady !== 1'b1 || MarkerReady !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b%b%b, required 111", CodeReady, FlushReady, MarkerReady);
    end
    waitCycles(1);
  endtask

  task automatic test_word_latency();
    int a;
    clearOut();
    sendCode(27'h123456, 5'd24, a);
    waitCycles(6);
    checkCount("t1_no_early_word", 0);
    sendCode(27'h78, 5'd8, a);
    waitCycles(4);
    checkCount("t1_count", 1);
    checkWord("t1_word", 0, 32'h12345678, 4, 1'b0);
    checks++;
    if (outC.size() < 1 || outC[0] - a !== 2) begin
      errors++; $display("FAIL t1_latency: got %0d, required 2", outC.size() < 1 ? -1 : outC[0] - a);
    end
  endtask

  task automatic test_stuffing();
    int a;
    clearOut();
    sendCode(27'hFFFFFF, 5'd24, a);
    sendFlush(1'b1);
    waitCycles(20);
    checkCount("t2_count", 2);
    checkWord("t2_word0", 0, 32'hFF00FF00, 4, 1'b0);
    checkWord("t2_word1", 1, 32'hFF000000, 2, 1'b1);
    checks++; if (EncodeIdle !== 1'b1) begin errors++; $display("FAIL t2_idle: got %b, required 1", EncodeIdle); end
  endtask

  task automatic test_pad();
    int a;
    clearOut();
    sendCode(27'b101, 5'd3, a);
    sendFlush(1'b1);
    waitCycles(15);
    checkCount("t3_count", 1);
    checkWord("t3_word", 0, 32'hBF000000, 1, 1'b1);
  endtask

  task automatic test_marker();
    int a;
    clearOut();
    sendCode(27'h0A, 5'd4, a);
    sendFlush(1'b0);
    sendMarker(8'hD0);
    sendCode(27'hAB, 5'd8, a);
    sendFlush(1'b1);
    waitCycles(20);
    checkCount("t4_count", 1);
    checkWord("t4_word", 0, 32'hAFFFD0AB, 4, 1'b0);
    checks++; if (EncodeIdle !== 1'b1) begin errors++; $display("FAIL t4_idle: got %b, required 1", EncodeIdle); end
  endtask

  task automatic test_backpressure();
    logic [26:0] dArr[12] = '{27'h7FFFFFF, 27'h1234567, 27'h0ABCD, 27'h3C5A, 27'h1FFF, 27'h5A5A5A5,
                               27'h0, 27'h1FF, 27'h7FFFF0A, 27'h2B, 27'hFF, 27'h6543210};
    logic [4:0] wArr[12] = '{5'd27, 5'd31, 5'd20, 5'd16, 5'd13, 5'd27, 5'd0, 5'd9, 5'd4, 5'd6, 5'd8, 5'd25};
    logic [7:0] expB[$], gotB[$];
    logic [7:0] b;
    int idx = 0, bad = -1;
    bit sawLow = 0;
    clearOut();
    bq.delete();
    fullViol = 0;
    for (int c = 0; c < 400 && idx < 12; c++) begin
      DataOutFull = c < 10;
      CodeValid = 1'b1; CodeData = dArr[idx]; CodeWidth = wArr[idx];
      @(negedge clk);
      if (DataOutFull && !CodeReady) sawLow = 1;
      if (CodeReady) begin
        for (int i = (wArr[idx] > 27 ? 27 : int'(wArr[idx])) - 1; i >= 0; i--) bq.push_back(dArr[idx][i]);
        idx++;
      end
      @(posedge clk); #1;
    end
    CodeValid = 1'b0; DataOutFull = 1'b0;
    sendFlush(1'b1);
    waitCycles(120);
    while (bq.size() % 8 != 0) bq.push_back(1'b1);
    for (int i = 0; i < bq.size(); i += 8) begin
      for (int j = 0; j < 8; j++) b[7-j] = bq[i+j];
      expB.push_back(b);
      if (b == 8'hFF) expB.push_back(8'h00);
    end
    for (int k = 0; k < outW.size(); k++)
      for (int j = 0; j < outB[k]; j++) gotB.push_back(outW[k][31-8*j -: 8]);
    checks++; if (idx !== 12) begin errors++; $display("FAIL t5_accepted: got %0d codes, required 12", idx); end
    checks++; if (!sawLow) begin errors++; $display("FAIL t5_ready_drop: CodeReady stayed 1 while Full, required a 0"); end
    checks++; if (fullViol !== 0) begin errors++; $display("FAIL t5_full_enable: got %0d strobes while Full, required 0", fullViol); end
    checks++; if (gotB.size() !== expB.size()) begin errors++; $display("FAIL t5_len: got %0d bytes, required %0d", gotB.size(), expB.size()); end
    for (int i = 0; i < expB.size() && i < gotB.size() && bad < 0; i++) if (gotB[i] !== expB[i]) bad = i;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL t5_stream: byte %0d got %h, required %h", bad, gotB[bad], expB[bad]); end
    checks++;
    if (outL.size() == 0 || outL[outL.size()-1] !== (expB.size() % 4 != 0)) begin
      errors++; $display("FAIL t5_last: got %0d, required %0d", outL.size() == 0 ? 0 : outL[outL.size()-1], expB.size() % 4 != 0);
    end
  endtask

  task automatic test_midstream_reset();
    int a;
    clearOut();
    sendCode(27'h1ABCDE, 5'd21, a);
    waitCycles(4);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (EncodeIdle !== 1'b1) begin errors++; $display("FAIL t6_idle: got %b, required 1", EncodeIdle); end
    checks++; if (DataOutEnable !== 1'b0) begin errors++; $display("FAIL t6_enable: got %b, required 0", DataOutEnable); end
    waitCycles(6);
    checkCount("t6_no_output", 0);
    sendCode(27'hDEAD, 5'd16, a);
    sendCode(27'hBEEF, 5'd16, a);
    sendFlush(1'b1);
    waitCycles(15);
    checkCount("t6_count", 1);
    checkWord("t6_word", 0, 32'hDEADBEEF, 4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_word_latency();
    test_stuffing();
    test_pad();
    test_marker();
    test_backpressure();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
